// File: rtl/ps2_rx_frame_pkg.sv
// Shared PS/2 receive definitions: FSM encoding, default tuning and protocol bytes.
// Also used by keyboard_press_driver for the break/extend prefixes.
package ps2_pkg;

    localparam int unsigned SYNC_STAGES_DEF    = 2;
    localparam int unsigned FILTER_LEN_DEF     = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 100000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXTEND = 8'hE0;

    // Odd parity over data+parity, and the stop bit must be high.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return stop & (^{data, par});
    endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Scan-code handshake between the PS/2 receiver (master) and its consumer (slave).
interface ps2_rx_frame_if;

    logic       read;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic       frame_err;
    logic       overrun;

    modport master (
        input  read,
        output scan_ready,
        output scan_code,
        output frame_err,
        output overrun
    );

    modport slave (
        output read,
        input  scan_ready,
        input  scan_code,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/ps2_rx_frame_clk_filter.sv
// PS/2 line front end: synchronisers, PS2_CLK run-length glitch filter and
// a one-cycle pulse on each filtered falling edge, plus the synchronised data line.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic PS2_CLK,
    input  logic PS2_DAT,
    output logic fall,
    output logic dat
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_filt;
    logic [CW-1:0]          run_len;
    logic                   clk_s;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat   = dat_sync[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
        end
    end

    // run_len counts consecutive samples that disagree with the filtered level;
    // the filtered clock flips on the FILTER_LEN-th such sample.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_filt <= 1'b1;
            run_len  <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == clk_filt) begin
                run_len <= '0;
            end else if (run_len == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s;
                run_len  <= '0;
                fall     <= clk_filt;
            end else begin
                run_len <= run_len + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver on CLOCK_50 with frame checking,
// stall watchdog and scan_ready/read handshake with overrun reporting.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic           PS2_CLK,
    input  logic           PS2_DAT,
    ps2_rx_frame_if.master bus
);

    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    logic          fall;
    logic          dat;
    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;
    logic [WW-1:0] wd;
    logic          commit;
    logic          reject;
    logic          timeout;

    logic          scan_ready_q;
    logic [7:0]    scan_code_q;
    logic          frame_err_q;
    logic          overrun_q;

    ps2_clk_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .fall     (fall),
        .dat      (dat)
    );

    always_comb begin
        commit  = 1'b0;
        reject  = 1'b0;
        timeout = 1'b0;
        if (fall && state == ST_STOP) begin
            commit = frame_ok(shreg, par, dat);
            reject = ~frame_ok(shreg, par, dat);
        end
        if (state != ST_IDLE && !fall && wd == WW'(TIMEOUT_CYCLES - 1))
            timeout = 1'b1;
    end

    // A timeout overrides the case-selected next state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            wd     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fall && !dat) begin
                        state  <= ST_DATA;
                        bitcnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (fall) begin
                        shreg[bitcnt] <= dat;
                        bitcnt        <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (fall) begin
                        par   <= dat;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fall)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (state == ST_IDLE || fall) begin
                wd <= '0;
            end else if (timeout) begin
                wd    <= '0;
                state <= ST_IDLE;
            end else begin
                wd <= wd + WW'(1);
            end
        end
    end

    // A commit takes priority over a coincident read.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            scan_ready_q <= 1'b0;
            scan_code_q  <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q <= reject | timeout;
            if (commit) begin
                scan_code_q  <= shreg;
                scan_ready_q <= 1'b1;
                overrun_q    <= scan_ready_q & ~bus.read;
            end else if (bus.read) begin
                scan_ready_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
        end
    end

    assign bus.scan_ready = scan_ready_q;
    assign bus.scan_code  = scan_code_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed self-checking bench for ps2_rx_frame; PS/2 bit rate and watchdog
// are scaled down so the whole run stays short.
module tb_ps2_rx_frame;

    localparam int unsigned TO   = 1000;
    localparam int unsigned HALF = 40;

    logic clk = 1'b0;
    logic rst;
    logic ps2c;
    logic ps2d;

    ps2_rx_frame_if bus();

    ps2_rx_frame #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .PS2_CLK  (ps2c),
        .PS2_DAT  (ps2d),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int ferr_pulses = 0;
    int ferr_cycles = 0;
    int last_ferr_cyc = 0;
    int fall_cyc = 0;
    logic prev_rdy = 1'b0;
    logic prev_ferr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.scan_ready && !prev_rdy)
            rise_cyc = cyc;
        if (bus.frame_err) begin
            ferr_cycles++;
            if (!prev_ferr) begin
                ferr_pulses++;
                last_ferr_cyc = cyc;
            end
        end
        prev_rdy  = bus.scan_ready;
        prev_ferr = bus.frame_err;
    end

    initial begin
        #(20 * 100000);
        $display("FAIL global_timeout: observed no finish, expected finish before 100000 cycles");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // rd_at > 0 raises read for one cycle so it is sampled rd_at edges after the raw fall.
    task automatic send_bit(input logic b, input int rd_at);
        @(negedge clk);
        ps2d = b;
        wait_neg(HALF);
        ps2c = 1'b0;
        fall_cyc = cyc;
        if (rd_at > 0) begin
            wait_neg(rd_at - 1);
            bus.read = 1'b1;
            wait_neg(1);
            bus.read = 1'b0;
            wait_neg(HALF - rd_at);
        end else begin
            wait_neg(HALF);
        end
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int rd_at);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++)
            send_bit(d[i], 0);
        send_bit(p, 0);
        send_bit(s, rd_at);
        wait_neg(20);
    endtask

    task automatic read_pulse();
        @(negedge clk);
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    int lat0;
    int lat;
    int p0;
    int diff;
    int stop_cyc;

    initial begin
        rst = 1'b1;
        ps2c = 1'b1;
        ps2d = 1'b1;
        bus.read = 1'b0;
        wait_neg(3);
        check("rst_ready", bus.scan_ready, 1'b0);
        check("rst_code", bus.scan_code, 8'h00);
        check("rst_ferr", bus.frame_err, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        rst = 1'b0;
        wait_neg(5);

        // bad parity, then bad stop
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        check("bad_ferr_pulses", ferr_pulses, 2);
        check("bad_ferr_cycles", ferr_cycles, 2);
        check("bad_ready", bus.scan_ready, 1'b0);
        check("bad_code", bus.scan_code, 8'h00);

        // good 0x1C frame
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++)
            send_bit(i >= 2 && i <= 4, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        stop_cyc = fall_cyc;
        wait_neg(20);
        lat0 = rise_cyc - stop_cyc;
        check("lat_in_range", (lat0 >= 1 && lat0 <= 12), 1'b1);
        check("good_ready", bus.scan_ready, 1'b1);
        check("good_code", bus.scan_code, 8'h1C);
        check("good_ferr", ferr_pulses, 2);
        check("good_overrun", bus.overrun, 1'b0);
        read_pulse();
        check("read_clears_ready", bus.scan_ready, 1'b0);

        // stall: start + 4 data bits of 0x1C, then clock held high
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        stop_cyc = fall_cyc;
        p0 = ferr_pulses;
        wait_neg(int'(TO) * 5 / 2);
        check("wd_one_pulse", ferr_pulses, p0 + 1);
        diff = last_ferr_cyc - stop_cyc;
        check("wd_delay", (diff >= int'(TO) && diff <= int'(TO) + 12), 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        lat = rise_cyc - fall_cyc;
        check("wd_next_code", bus.scan_code, 8'h5A);
        check("wd_next_ready", bus.scan_ready, 1'b1);
        check("lat_constant", lat, lat0);
        check("wd_no_extra_ferr", ferr_pulses, p0 + 1);

        // overrun and read handshake
        read_pulse();
        send_frame(8'hF0, 1'b1, 1'b1, 0);
        check("ovr_first_code", bus.scan_code, 8'hF0);
        check("ovr_first_flag", bus.overrun, 1'b0);
        send_frame(8'h29, 1'b0, 1'b1, 0);
        check("ovr_code", bus.scan_code, 8'h29);
        check("ovr_flag", bus.overrun, 1'b1);
        check("ovr_ready", bus.scan_ready, 1'b1);
        read_pulse();
        check("ovr_read_ready", bus.scan_ready, 1'b0);
        check("ovr_read_flag", bus.overrun, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        send_frame(8'h5A, 1'b1, 1'b1, lat0);
        check("coinc_ready", bus.scan_ready, 1'b1);
        check("coinc_overrun", bus.overrun, 1'b0);
        check("coinc_code", bus.scan_code, 8'h5A);

        // 5-cycle clock glitches with data low, every 1 us for 100 us
        p0 = ferr_pulses;
        @(negedge clk);
        ps2d = 1'b0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            ps2c = 1'b0;
            wait_neg(5);
            ps2c = 1'b1;
            wait_neg(44);
        end
        ps2d = 1'b1;
        wait_neg(20);
        check("glitch_ferr", ferr_pulses, p0);
        check("glitch_code", bus.scan_code, 8'h5A);
        read_pulse();
        send_frame(8'h16, 1'b0, 1'b1, 0);
        check("glitch_next_code", bus.scan_code, 8'h16);
        check("glitch_next_ready", bus.scan_ready, 1'b1);
        check("glitch_next_ferr", ferr_pulses, p0);

        // asynchronous reset mid-frame
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        check("pre_rst_overrun", bus.overrun, 1'b1);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_ready", bus.scan_ready, 1'b0);
        check("async_rst_code", bus.scan_code, 8'h00);
        check("async_rst_overrun", bus.overrun, 1'b0);
        check("async_rst_ferr", bus.frame_err, 1'b0);
        wait_neg(3);
        rst = 1'b0;
        p0 = ferr_pulses;
        wait_neg(5);
        send_frame(8'h16, 1'b0, 1'b1, 0);
        check("post_rst_code", bus.scan_code, 8'h16);
        check("post_rst_ready", bus.scan_ready, 1'b1);
        check("post_rst_overrun", bus.overrun, 1'b0);
        check("post_rst_ferr", ferr_pulses, p0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
